// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result capture path: capture FSM states,
// default channel geometry and the fixed channel-to-operation mapping.
package alu_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FULL = 1'b1
    } cap_state_e;

    localparam int unsigned ALU_WIDTH  = 8;
    localparam int unsigned ALU_NUM_CH = 4;
    localparam int unsigned ALU_SEL_W  = 3;

    // Result channel assignment inherited from the existing ALU datapath.
    localparam int unsigned CH_TRANSFER = 0;
    localparam int unsigned CH_ADDSUB   = 1;
    localparam int unsigned CH_GATE     = 2;
    localparam int unsigned CH_COMPARE  = 3;

endpackage

// File: rtl/result_select_comb.sv
// NUM_CH:1 combinational result select with an in-range flag for Select.
// Purely combinational; all state lives in the parent capture block.
module result_select_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = ALU_WIDTH,
    parameter int unsigned NUM_CH = ALU_NUM_CH,
    parameter int unsigned SEL_W  = ALU_SEL_W
) (
    input  logic [NUM_CH*WIDTH-1:0] Results,
    input  logic [SEL_W-1:0]        Select,
    output logic [WIDTH-1:0]        Sel_Data,
    output logic                    Sel_Ok
);

    // Pick the addressed channel; out-of-range selects yield zero and are
    // rejected by Sel_Ok, so the data value never reaches a register.
    always_comb begin
        Sel_Data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (Select == SEL_W'(i)) begin
                Sel_Data = Results[i*WIDTH +: WIDTH];
            end
        end
    end

    assign Sel_Ok = (32'(Select) < NUM_CH);

endmodule

// File: rtl/result_capture_mux.sv
// Captures one ALU result channel into an output register on Flag, with a
// one-entry valid/ready handshake toward the consumer, sticky error flags
// and a wrapping count of successful captures. All outputs are registered.
module result_capture_mux
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = ALU_WIDTH,
    parameter int unsigned NUM_CH = ALU_NUM_CH,
    parameter int unsigned SEL_W  = ALU_SEL_W,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Flag,
    input  logic [NUM_CH*WIDTH-1:0] Results,
    input  logic [SEL_W-1:0]        Select,
    input  logic                    Out_Ready,
    input  logic                    Err_Clr,
    output logic [WIDTH-1:0]        Mux_Out,
    output logic [SEL_W-1:0]        Out_Ch,
    output logic                    Out_Valid,
    output logic                    Sel_Err,
    output logic                    Overrun,
    output logic [CNT_W-1:0]        Cap_Count
);

    cap_state_e       state_q, state_d;
    logic [WIDTH-1:0] mux_out_q;
    logic [SEL_W-1:0] out_ch_q;
    logic             sel_err_q, overrun_q;
    logic [CNT_W-1:0] cap_count_q;

    logic [WIDTH-1:0] sel_data;
    logic             sel_ok;
    logic             capture;
    logic             drain;

    result_select_comb #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_select (
        .Results  (Results),
        .Select   (Select),
        .Sel_Data (sel_data),
        .Sel_Ok   (sel_ok)
    );

    // A pending result frees its slot in the same cycle it is drained, which
    // lets a new capture land back-to-back without a bubble.
    assign drain   = (state_q == FULL) && Out_Ready;
    assign capture = Flag && sel_ok && ((state_q == IDLE) || Out_Ready);

    // Capture FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: capture wins over drain; otherwise hold.
    always_comb begin
        state_d = state_q;
        if (capture) begin
            state_d = FULL;
        end else if (drain) begin
            state_d = IDLE;
        end
    end

    // Data, channel, counter and sticky error registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mux_out_q   <= '0;
            out_ch_q    <= '0;
            cap_count_q <= '0;
            sel_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (capture) begin
                mux_out_q   <= sel_data;
                out_ch_q    <= Select;
                cap_count_q <= cap_count_q + 1'b1;
            end
            // Set has priority over a coincident clear.
            sel_err_q <= (Flag && !sel_ok) || (sel_err_q && !Err_Clr);
            overrun_q <= (Flag && (state_q == FULL) && !Out_Ready) || (overrun_q && !Err_Clr);
        end
    end

    assign Mux_Out   = mux_out_q;
    assign Out_Ch    = out_ch_q;
    assign Out_Valid = (state_q == FULL);
    assign Sel_Err   = sel_err_q;
    assign Overrun   = overrun_q;
    assign Cap_Count = cap_count_q;

endmodule

// File: doc/result_capture_mux.md
RESULT_CAPTURE_MUX -- requirements
Module: result_capture_mux

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each ALU result channel and of Mux_Out.
REQ-002 Parameter NUM_CH, default 4, number of result channels; legal range 2..8.
REQ-003 Parameter SEL_W, default 3, width of Select; SHALL satisfy 2**SEL_W >= NUM_CH.
REQ-004 Parameter CNT_W, default 8, width of the capture counter.
REQ-005 Clk  input  1  single clock; all state changes on posedge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 Flag  input  1  capture request, sampled on posedge Clk.
REQ-008 Results  input  NUM_CH*WIDTH  flattened results; channel i at bits [i*WIDTH +: WIDTH].
REQ-009 Select  input  SEL_W  channel to capture.
REQ-010 Out_Ready  input  1  downstream accepts Mux_Out this cycle.
REQ-011 Err_Clr  input  1  synchronous clear of sticky error flags.
REQ-012 Mux_Out  output  WIDTH  registered captured result.
REQ-013 Out_Ch  output  SEL_W  registered channel index of Mux_Out.
REQ-014 Out_Valid  output  1  Mux_Out holds an unconsumed result.
REQ-015 Sel_Err  output  1  sticky: capture requested with Select >= NUM_CH.
REQ-016 Overrun  output  1  sticky: capture requested while result pending and not drained.
REQ-017 Cap_Count  output  CNT_W  number of successful captures, modulo 2**CNT_W.

Function
REQ-018 FSM states SHALL be IDLE (Out_Valid=0) and FULL (Out_Valid=1); Out_Valid is decoded directly from state.
REQ-019 A capture SHALL occur on a posedge when Flag=1, Select<NUM_CH, and (state=IDLE or Out_Ready=1).
REQ-020 On capture: Mux_Out <= channel Select of Results, Out_Ch <= Select, Cap_Count increments, next state FULL; latency one cycle from Flag sample to Out_Valid=1.
REQ-021 FULL with Out_Ready=1 and no capture SHALL return to IDLE; Mux_Out and Out_Ch SHALL hold last value.
REQ-022 FULL with Out_Ready=1 and a capture in the same cycle SHALL stay FULL with new data (back-to-back, no bubble).
REQ-023 FULL with Out_Ready=0 and Flag=1 SHALL drop the request, hold Mux_Out/Out_Ch, and set Overrun.
REQ-024 Flag=1 with Select>=NUM_CH SHALL set Sel_Err, perform no capture, leave data registers unchanged; state follows REQ-021 drain rule.
REQ-025 Out_Ready in IDLE SHALL be ignored.
REQ-026 Flag=0 SHALL never change Mux_Out, Out_Ch or Cap_Count.
REQ-027 Cap_Count SHALL wrap from 2**CNT_W-1 to 0 without side effects.
REQ-028 Err_Clr=1 SHALL clear Sel_Err and Overrun; if a set condition coincides, set SHALL win.
REQ-029 No combinational path SHALL exist from any input to any output.

Reset
REQ-030 Reset=1 SHALL asynchronously force state IDLE, Mux_Out=0, Out_Ch=0, Out_Valid=0, Sel_Err=0, Overrun=0, Cap_Count=0.
REQ-031 Reset asserted mid-operation SHALL discard any pending result; first capture after release behaves as from IDLE.
REQ-032 No simulation-only output (display/print) SHALL be generated for any input combination.

Structure
REQ-033 Shared package alu_pkg SHALL hold the FSM state enum (IDLE, FULL) and default constants ALU_WIDTH=8, ALU_NUM_CH=4, ALU_SEL_W=3.
REQ-034 Channel indexing SHALL map existing encodings: 0 transfer, 1 adder/subtractor, 2 gate, 3 comparator.
REQ-035 One sub-module, result_select_comb, SHALL implement the parametrised NUM_CH:1 combinational select plus in-range check; all registers stay in result_capture_mux.

Verification
REQ-036 Defaults; Results={8'h44,8'h33,8'h22,8'h11}, Select=1, Flag=1 one cycle -> next cycle Mux_Out=8'h22, Out_Ch=1, Out_Valid=1, Cap_Count=1.
REQ-037 FULL, Out_Ready=0, Flag=1 Select=3 -> Mux_Out stays 8'h22, Overrun=1; Err_Clr pulse -> Overrun=0.
REQ-038 FULL, Out_Ready=1 and Flag=1 Select=3 same cycle -> Mux_Out=8'h44, Out_Valid stays 1; next cycle Out_Ready=1 Flag=0 -> Out_Valid=0, Mux_Out holds 8'h44.
REQ-039 Flag=1 Select=5 -> Sel_Err=1, Mux_Out and Cap_Count unchanged, no console output.
REQ-040 255 captures then one more with CNT_W=8 -> Cap_Count 8'hFF then 8'h00.
REQ-041 Reset asserted between posedges while FULL -> all outputs 0 immediately; NUM_CH=8, WIDTH=16 rerun of REQ-036 with Select=7 -> correct channel captured.
